cu_sequencer: RTL and testbench
===============================

# cu_sequencer

Control-unit sequencer that drives the enable and synchronous-reset inputs of the CPU's 5-bit step counter. It fetches opcodes, including the CB-prefixed second byte, into the instruction register and holds the counter during bus wait states. It also ends instructions, enters and leaves HALT, and runs the interrupt-dispatch sequence. It sits between the bus interface, the opcode decoder and the step counter.

## Interface
- IRQ_STEPS, 5: step count of the interrupt-dispatch sequence (steps 0..IRQ_STEPS-1).
- MAX_STEP, 31: step value at which an unfinished instruction is declared hung.
- i_Clk  in  1  system clock; all state changes on its rising edge.
- i_nRst  in  1  reset; one clock, asynchronous, active-low.
- i_Step  in  5  current step from the step counter.
- i_Opcode  in  8  data-bus byte, valid when i_BusReady=1 during FETCH.
- i_BusReady  in  1  bus cycle complete this clock; 0 = wait state.
- i_InstrDone  in  1  decoder: current step is the last step of the instruction.
- i_Halt  in  1  decoder: executing instruction is HALT; sampled with i_InstrDone.
- i_IrqPending  in  1  an enabled interrupt is flagged (IE & IF != 0).
- i_IME  in  1  interrupt master enable.
- o_StepEnable  out  1  step counter enable.
- o_StepReset  out  1  step counter synchronous return-to-0.
- o_FetchReq  out  1  request an opcode read at PC.
- o_IR  out  8  instruction register.
- o_CBPrefix  out  1  o_IR holds a CB-page opcode.
- o_State  out  2  0=FETCH, 1=EXEC, 2=HALT, 3=IRQ.
- o_IrqAck  out  1  one-cycle pulse: dispatch complete, clear IF bit.
- o_Fault  out  1  sticky: hang detected.

## Operation
- Reset (i_nRst=0, asynchronous): state FETCH, o_IR=8'h00, o_CBPrefix=0, o_Fault=0, o_IrqAck=0.
- Registered: state, o_IR, o_CBPrefix, o_Fault, o_IrqAck.
- Combinational (from state and inputs): o_StepEnable, o_StepReset, o_FetchReq.
- FETCH:
  - o_FetchReq=1, o_StepEnable=1, o_StepReset=1; the counter is held at 0.
  - On i_BusReady=1, o_IR <= i_Opcode.
  - If i_Opcode==8'hCB and o_CBPrefix=0: o_CBPrefix <= 1 and remain in FETCH to read the second byte.
  - Otherwise go to EXEC.
  - A second CB byte read while o_CBPrefix=1 is a normal CB opcode and goes to EXEC.
- EXEC:
  - o_FetchReq=0, o_StepEnable=i_BusReady, o_StepReset=0.
  - With i_BusReady=0 the step counter and the state are frozen.
  - On i_InstrDone=1 and i_BusReady=1:
    - o_StepReset=1 and o_CBPrefix <= 0.
    - Next state by priority: i_Halt gives HALT; else i_IrqPending & i_IME gives IRQ; else FETCH.
  - Hang: if i_Step==MAX_STEP, i_InstrDone=0 and i_BusReady=1, then o_Fault <= 1, o_StepReset=1, o_CBPrefix <= 0, next FETCH.
- HALT:
  - o_StepEnable=1, o_StepReset=1, o_FetchReq=0.
  - On i_IrqPending=1: go to IRQ if i_IME=1, else FETCH (HALT exit without dispatch).
- IRQ:
  - o_StepEnable=i_BusReady, o_StepReset=0, o_FetchReq=0.
  - When i_Step==IRQ_STEPS-1 and i_BusReady=1:
    - o_StepReset=1 and o_IrqAck <= 1 for exactly one cycle.
    - Next state FETCH.
  - i_IME and i_IrqPending are not re-sampled inside IRQ; dispatch always completes.
- o_Fault clears only on reset.

## Timing
- Opcode fetch: o_IR is valid the cycle after the i_BusReady=1 edge; EXEC starts at step 0 on that same edge.
- A CB instruction costs two FETCH bus cycles before EXEC.
- Instruction end, decision and counter return-to-0 all happen on the same edge. The next FETCH is the next cycle, with zero bubble.
- Wait states stretch any state indefinitely with no loss of the step count.
- o_IrqAck is high for the one cycle following the last dispatch step, while state is already FETCH.
- HALT wake-up: the cycle after i_IrqPending rises, o_State is IRQ or FETCH.
- Simultaneous i_InstrDone & i_Halt & i_IrqPending: HALT wins. The interrupt is taken from HALT on the following cycle.
- Asynchronous reset mid-instruction or mid-dispatch: outputs return to reset values immediately, with no o_IrqAck pulse.

## Test plan
- Reset, then opcode 8'h00 with i_BusReady=1 and i_InstrDone at step 3 -> o_IR=00, states FETCH,EXEC×4,FETCH; o_StepReset high on the step-3 edge.
- Bytes CB then 37 -> o_CBPrefix=1 after the first byte; o_IR=37 in EXEC; o_CBPrefix=0 after i_InstrDone.
- Hold i_BusReady=0 for 3 cycles at EXEC step 2 -> o_StepEnable=0 and o_State=EXEC throughout; completes normally after release.
- HALT (i_InstrDone & i_Halt), then i_IrqPending=1 with i_IME=1 -> HALT, then IRQ for 5 steps, a single o_IrqAck pulse, then FETCH. Repeat with i_IME=0 -> FETCH with no o_IrqAck.
- EXEC with i_InstrDone never asserted -> at i_Step=31, o_Fault=1 and o_State=FETCH; o_Fault stays 1 until i_nRst=0.
- Drop i_nRst at IRQ step 2 -> immediate o_State=0, o_IR=00 and o_IrqAck=0; normal fetch after release.

Source files
------------

// File: rtl/cu_sequencer.sv
// cu_sequencer: step-counter control, opcode fetch, HALT and interrupt-dispatch sequencing
module cu_sequencer #(
  parameter int IRQ_STEPS = 5,
  parameter int MAX_STEP  = 31
) (
  input  logic       i_Clk,
  input  logic       i_nRst,
  input  logic [4:0] i_Step,
  input  logic [7:0] i_Opcode,
  input  logic       i_BusReady,
  input  logic       i_InstrDone,
  input  logic       i_Halt,
  input  logic       i_IrqPending,
  input  logic       i_IME,
  output logic       o_StepEnable,
  output logic       o_StepReset,
  output logic       o_FetchReq,
  output logic [7:0] o_IR,
  output logic       o_CBPrefix,
  output logic [1:0] o_State,
  output logic       o_IrqAck,
  output logic       o_Fault
);
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_HALT = 2'd2, S_IRQ = 2'd3} state_t;

  localparam logic [4:0] L_MAX_STEP = 5'(MAX_STEP);
  localparam logic [4:0] L_IRQ_LAST = 5'(IRQ_STEPS - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_ir;
  logic       r_cb;
  logic       r_fault;
  logic       r_ack;
  logic       w_ir_load;
  logic       w_cb_set;
  logic       w_cb_clr;
  logic       w_fault_set;
  logic       w_ack;
  logic       w_fin;
  logic       w_hang;
  logic       w_irq_last;

  assign w_fin      = (r_state == S_EXEC) && i_BusReady && i_InstrDone;
  assign w_hang     = (r_state == S_EXEC) && i_BusReady && !i_InstrDone && (i_Step == L_MAX_STEP);
  assign w_irq_last = (r_state == S_IRQ) && i_BusReady && (i_Step == L_IRQ_LAST);

  // Next-state and counter-control decode; a wait state holds both counter and state
  always_comb begin
    w_next       = r_state;
    o_StepEnable = 1'b0;
    o_StepReset  = 1'b0;
    o_FetchReq   = 1'b0;
    w_ir_load    = 1'b0;
    w_cb_set     = 1'b0;
    w_cb_clr     = 1'b0;
    w_fault_set  = 1'b0;
    w_ack        = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_FetchReq   = 1'b1;
        o_StepEnable = 1'b1;
        o_StepReset  = 1'b1;
        if (i_BusReady) begin
          w_ir_load = 1'b1;
          if (i_Opcode == 8'hCB && !r_cb) w_cb_set = 1'b1;
          else w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        o_StepEnable = i_BusReady;
        if (w_fin) begin
          o_StepReset = 1'b1;
          w_cb_clr    = 1'b1;
          w_next      = i_Halt ? S_HALT : (i_IrqPending && i_IME) ? S_IRQ : S_FETCH;
        end else if (w_hang) begin
          o_StepReset = 1'b1;
          w_cb_clr    = 1'b1;
          w_fault_set = 1'b1;
          w_next      = S_FETCH;
        end
      end
      S_HALT: begin
        o_StepEnable = 1'b1;
        o_StepReset  = 1'b1;
        if (i_IrqPending) w_next = i_IME ? S_IRQ : S_FETCH;
      end
      default: begin
        o_StepEnable = i_BusReady;
        if (w_irq_last) begin
          o_StepReset = 1'b1;
          w_ack       = 1'b1;
          w_next      = S_FETCH;
        end
      end
    endcase
  end

  // State, instruction register, CB page flag, sticky fault and registered ack pulse
  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      r_state <= S_FETCH;
      r_ir    <= 8'h00;
      r_cb    <= 1'b0;
      r_fault <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ack   <= w_ack;
      if (w_ir_load) r_ir <= i_Opcode;
      if (w_cb_set) r_cb <= 1'b1;
      else if (w_cb_clr) r_cb <= 1'b0;
      if (w_fault_set) r_fault <= 1'b1;
    end
  end

  assign o_IR       = r_ir;
  assign o_CBPrefix = r_cb;
  assign o_State    = r_state;
  assign o_IrqAck   = r_ack;
  assign o_Fault    = r_fault;
endmodule

// File: tb/tb_cu_sequencer.sv
// tb_cu_sequencer: random and directed checking of cu_sequencer against a cycle reference model
module tb_cu_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] step = 5'd0;
  logic [7:0] opcode = 8'h00;
  logic       bus_ready = 1'b0;
  logic       instr_done = 1'b0;
  logic       halt = 1'b0;
  logic       irq_pending = 1'b0;
  logic       ime = 1'b0;
  logic       step_enable, step_reset, fetch_req, cb_prefix, irq_ack, fault;
  logic [7:0] ir;
  logic [1:0] state;

  int n_total = 0;
  int n_bad = 0;
  int acks = 0;

  int         m_state;
  logic [7:0] m_ir;
  logic       m_cb, m_fault, m_ack;
  logic [4:0] m_step;

  always #5 clk = ~clk;

  cu_sequencer dut (
    .i_Clk(clk), .i_nRst(rst_n), .i_Step(step), .i_Opcode(opcode),
    .i_BusReady(bus_ready), .i_InstrDone(instr_done), .i_Halt(halt),
    .i_IrqPending(irq_pending), .i_IME(ime),
    .o_StepEnable(step_enable), .o_StepReset(step_reset), .o_FetchReq(fetch_req),
    .o_IR(ir), .o_CBPrefix(cb_prefix), .o_State(state), .o_IrqAck(irq_ack), .o_Fault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_ir    = 8'h00;
    m_cb    = 1'b0;
    m_fault = 1'b0;
    m_ack   = 1'b0;
    m_step  = 5'd0;
    step    = 5'd0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ":state"}, 32'(state), 32'(m_state));
    chk({tag, ":ir"}, 32'(ir), 32'(m_ir));
    chk({tag, ":cb"}, 32'(cb_prefix), 32'(m_cb));
    chk({tag, ":fault"}, 32'(fault), 32'(m_fault));
    chk({tag, ":ack"}, 32'(irq_ack), 32'(m_ack));
  endtask

  // one clock: drive inputs, check counter controls, clock, advance model and counter, check registers
  task automatic cycle(input logic bus, input logic [7:0] op, input logic done,
                       input logic hl, input logic irq, input logic ie);
    logic e_en, e_rst, e_fr, fin, hang, last;
    int ns;
    logic [7:0] nir;
    logic ncb, nf, nack;
    bus_ready = bus; opcode = op; instr_done = done; halt = hl; irq_pending = irq; ime = ie;
    #1;
    fin   = (m_state == 1) && bus && done;
    hang  = (m_state == 1) && bus && !done && (m_step == 5'd31);
    last  = (m_state == 3) && bus && (m_step == 5'd4);
    e_fr  = (m_state == 0);
    e_en  = (m_state == 0 || m_state == 2) ? 1'b1 : bus;
    e_rst = (m_state == 0 || m_state == 2 || fin || hang || last);
    chk("fetch_req", 32'(fetch_req), 32'(e_fr));
    chk("step_en", 32'(step_enable), 32'(e_en));
    chk("step_rst", 32'(step_reset), 32'(e_rst));
    ns = m_state; nir = m_ir; ncb = m_cb; nf = m_fault; nack = 1'b0;
    case (m_state)
      0: if (bus) begin
           nir = op;
           if (op == 8'hCB && !m_cb) ncb = 1'b1;
           else ns = 1;
         end
      1: if (fin) begin
           ncb = 1'b0;
           ns = hl ? 2 : (irq && ie) ? 3 : 0;
         end else if (hang) begin
           nf = 1'b1; ncb = 1'b0; ns = 0;
         end
      2: if (irq) ns = ie ? 3 : 0;
      default: if (last) begin nack = 1'b1; ns = 0; end
    endcase
    @(posedge clk);
    #1;
    if (e_en) m_step = e_rst ? 5'd0 : m_step + 5'd1;
    step = m_step;
    m_state = ns; m_ir = nir; m_cb = ncb; m_fault = nf; m_ack = nack;
    if (irq_ack) acks++;
    check_regs("cyc");
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset");
    rst_n = 1'b1;

    cycle(1, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 8'h00, 0, 0, 0, 0);
    chk("nop_step3", 32'(step), 32'd3);
    cycle(1, 8'h00, 1, 0, 0, 0);
    chk("nop_end_state", 32'(state), 32'd0);

    cycle(1, 8'hCB, 0, 0, 0, 0);
    chk("cb_first", 32'(cb_prefix), 32'd1);
    chk("cb_stay", 32'(state), 32'd0);
    cycle(1, 8'h37, 0, 0, 0, 0);
    chk("cb_ir", 32'(ir), 32'h37);
    chk("cb_exec", 32'(state), 32'd1);
    cycle(1, 8'h00, 1, 0, 0, 0);
    chk("cb_clear", 32'(cb_prefix), 32'd0);

    cycle(1, 8'h5A, 0, 0, 0, 0);
    cycle(1, 8'h00, 0, 0, 0, 0);
    cycle(1, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 8'h00, 1, 0, 0, 0);
      chk("wait_state", 32'(state), 32'd1);
      chk("wait_step", 32'(step), 32'd2);
    end
    cycle(1, 8'h00, 1, 0, 0, 0);
    chk("wait_done", 32'(state), 32'd0);

    acks = 0;
    cycle(1, 8'h76, 0, 0, 0, 0);
    cycle(1, 8'h00, 1, 1, 1, 1);
    chk("halt_wins", 32'(state), 32'd2);
    cycle(1, 8'h00, 0, 0, 1, 1);
    chk("halt_wake_irq", 32'(state), 32'd3);
    for (int i = 0; i < 5; i++) cycle(1, 8'h00, 0, 0, 0, 0);
    chk("irq_ack_pulse", 32'(irq_ack), 32'd1);
    chk("irq_done_state", 32'(state), 32'd0);
    cycle(0, 8'h00, 0, 0, 0, 0);
    chk("irq_ack_once", 32'(acks), 32'd1);
    cycle(1, 8'h76, 0, 0, 0, 0);
    cycle(1, 8'h00, 1, 1, 0, 0);
    cycle(1, 8'h00, 0, 0, 1, 0);
    chk("halt_wake_noime", 32'(state), 32'd0);
    cycle(1, 8'h00, 0, 0, 0, 0);
    chk("noime_no_ack", 32'(acks), 32'd1);

    cycle(1, 8'h00, 0, 0, 0, 0);
    cycle(1, 8'h3C, 0, 0, 0, 0);
    cycle(1, 8'h00, 1, 1, 0, 0);
    cycle(1, 8'h00, 0, 0, 1, 1);
    cycle(1, 8'h00, 0, 0, 0, 0);
    cycle(1, 8'h00, 0, 0, 0, 0);
    chk("irq_step2", 32'(step), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_ir", 32'(ir), 32'd0);
    chk("arst_ack", 32'(irq_ack), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1, 8'h21, 0, 0, 0, 0);
    chk("post_reset_fetch", 32'(ir), 32'h21);

    for (int i = 0; i < 32; i++) cycle(1, 8'h00, 0, 0, 0, 0);
    chk("hang_fault", 32'(fault), 32'd1);
    chk("hang_state", 32'(state), 32'd0);

    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) < 8 ? 1'b1 : 1'b0,
            $urandom_range(0, 3) == 0 ? 8'hCB : 8'($urandom),
            $urandom_range(0, 4) == 0 ? 1'b1 : 1'b0,
            $urandom_range(0, 4) == 0 ? 1'b1 : 1'b0,
            $urandom_range(0, 6) == 0 ? 1'b1 : 1'b0,
            $urandom_range(0, 1) == 0 ? 1'b1 : 1'b0);
    chk("fault_sticky", 32'(fault), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("fault_cleared", 32'(fault), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 9) < 7 ? 1'b1 : 1'b0,
            $urandom_range(0, 3) == 0 ? 8'hCB : 8'($urandom),
            $urandom_range(0, 3) == 0 ? 1'b1 : 1'b0,
            $urandom_range(0, 5) == 0 ? 1'b1 : 1'b0,
            $urandom_range(0, 4) == 0 ? 1'b1 : 1'b0,
            $urandom_range(0, 2) != 0 ? 1'b1 : 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
